// File: rtl/sci_acc_pkg.sv
// rtl/sci_acc_pkg.sv - shared widths, mode encoding and response header layout for the accelerator responder
package sci_acc_pkg;
   localparam int NUM_MODE_BITS       = 2;
   localparam int NUM_RES_BITS        = 4;
   localparam int IEEE_32BIT          = 32;
   localparam int RES_FIFO_DATA_WIDTH = 8;
   localparam int NUM_RESP_BYTES      = 5;
   localparam int RESP_WIDTH          = NUM_RESP_BYTES * RES_FIFO_DATA_WIDTH;

   localparam int HDR_ERR_BIT  = 7;
   localparam int HDR_MODE_LSB = 4;
   localparam int HDR_RES_LSB  = 0;

   localparam logic [IEEE_32BIT-1:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [NUM_MODE_BITS-1:0] {
      MODE_EXP = 2'd0,
      MODE_SIN = 2'd1,
      MODE_COS = 2'd2
   } sci_mode_e;

   function automatic logic mode_is_legal(input logic [NUM_MODE_BITS-1:0] m);
      return m <= NUM_MODE_BITS'(MODE_COS);
   endfunction

   function automatic logic [RES_FIFO_DATA_WIDTH-1:0] make_header(
      input logic                     err,
      input logic [NUM_MODE_BITS-1:0] mode,
      input logic [NUM_RES_BITS-1:0]  res
   );
      logic [RES_FIFO_DATA_WIDTH-1:0] h;
      h                        = '0;
      h[HDR_ERR_BIT]           = err;
      h[HDR_MODE_LSB +: 3]     = {1'b0, mode};
      h[HDR_RES_LSB +: NUM_RES_BITS] = res;
      return h;
   endfunction
endpackage

// File: rtl/sci_acc_req_resp_gen_resp_byte_serializer.sv
// rtl/sci_acc_req_resp_gen_resp_byte_serializer.sv - shifts a loaded 5-byte response into the result FIFO, MSB byte first
module resp_byte_serializer
   import sci_acc_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           load,
   input  logic [RESP_WIDTH-1:0]          load_word,
   input  logic                           fifo_full,
   output logic                           push,
   output logic [RES_FIFO_DATA_WIDTH-1:0] data,
   output logic                           done
);
   logic [RESP_WIDTH-1:0] shreg;
   logic [2:0]            idx;
   logic                  busy;

   assign push = busy & ~fifo_full;
   assign data = shreg[RESP_WIDTH-1 -: RES_FIFO_DATA_WIDTH];
   assign done = push && (idx == 3'(NUM_RESP_BYTES - 1));

   // The shift only happens on an accepted push, so a full FIFO holds the current byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg <= '0;
         idx   <= '0;
         busy  <= 1'b0;
      end else if (load) begin
         shreg <= load_word;
         idx   <= '0;
         busy  <= 1'b1;
      end else if (push) begin
         shreg <= shreg << RES_FIFO_DATA_WIDTH;
         if (done) begin
            idx  <= '0;
            busy <= 1'b0;
         end else begin
            idx <= idx + 3'd1;
         end
      end
   end
endmodule

// File: rtl/sci_acc_req_resp_gen.sv
// rtl/sci_acc_req_resp_gen.sv - accelerator request responder; SCI_ACC_RESP_TIMEOUT_EN adds a core watchdog
module sci_acc_req_resp_gen
   import sci_acc_pkg::*;
`ifdef SCI_ACC_RESP_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = 1024
)
`endif
(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           req_vld,
   input  logic [NUM_MODE_BITS-1:0]       req_mode,
   input  logic [NUM_RES_BITS-1:0]        req_res,
   input  logic [IEEE_32BIT-1:0]          req_data,
   output logic                           intf_ready,
   output logic                           resp_gen_cmpltd,
   output logic                           core_start,
   output logic [NUM_MODE_BITS-1:0]       core_mode,
   output logic [NUM_RES_BITS-1:0]        core_res,
   output logic [IEEE_32BIT-1:0]          core_arg,
   input  logic                           core_done,
   input  logic [IEEE_32BIT-1:0]          core_result,
   output logic                           res_fifo_push,
   output logic [RES_FIFO_DATA_WIDTH-1:0] res_fifo_data_in,
   input  logic                           res_fifo_full
);
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_PUSH  = 3'd3;
   localparam logic [2:0] ST_CMPLT = 3'd4;

   logic [2:0]            state;
   logic                  ser_load;
   logic [RESP_WIDTH-1:0] ser_word;
   logic                  ser_done;
   logic                  timeout_hit;

`ifdef SCI_ACC_RESP_TIMEOUT_EN
   logic [31:0] to_cnt;

   assign timeout_hit = (state == ST_WAIT) && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset || state != ST_WAIT)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 32'd1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign intf_ready      = (state == ST_IDLE);
   assign core_start      = (state == ST_START);
   assign resp_gen_cmpltd = (state == ST_CMPLT);

   // The serializer is loaded on the cycle the response becomes known; core_done beats a coincident timeout.
   always_comb begin
      ser_load = 1'b0;
      ser_word = '0;
      case (state)
         ST_IDLE: if (req_vld && !mode_is_legal(req_mode)) begin
            ser_load = 1'b1;
            ser_word = {make_header(1'b1, req_mode, req_res), {IEEE_32BIT{1'b0}}};
         end
         ST_WAIT: if (core_done) begin
            ser_load = 1'b1;
            ser_word = {make_header(1'b0, core_mode, core_res), core_result};
         end else if (timeout_hit) begin
            ser_load = 1'b1;
            ser_word = {make_header(1'b1, core_mode, core_res), QNAN};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         core_mode <= '0;
         core_res  <= '0;
         core_arg  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (req_vld) begin
               core_mode <= req_mode;
               core_res  <= req_res;
               core_arg  <= req_data;
               state     <= mode_is_legal(req_mode) ? ST_START : ST_PUSH;
            end
            ST_START: state <= ST_WAIT;
            ST_WAIT:  if (ser_load) state <= ST_PUSH;
            ST_PUSH:  if (ser_done) state <= ST_CMPLT;
            ST_CMPLT: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   resp_byte_serializer u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .load_word (ser_word),
      .fifo_full (res_fifo_full),
      .push      (res_fifo_push),
      .data      (res_fifo_data_in),
      .done      (ser_done)
   );
endmodule

// File: tb/tb_sci_acc_req_resp_gen.sv
// tb/tb_sci_acc_req_resp_gen.sv - directed vector bench for sci_acc_req_resp_gen
module tb_sci_acc_req_resp_gen;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_vld;
   logic [1:0]  req_mode;
   logic [3:0]  req_res;
   logic [31:0] req_data;
   logic        intf_ready;
   logic        resp_gen_cmpltd;
   logic        core_start;
   logic [1:0]  core_mode;
   logic [3:0]  core_res;
   logic [31:0] core_arg;
   logic        core_done;
   logic [31:0] core_result;
   logic        res_fifo_push;
   logic [7:0]  res_fifo_data_in;
   logic        res_fifo_full;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

`ifdef SCI_ACC_RESP_TIMEOUT_EN
   sci_acc_req_resp_gen #(.TIMEOUT_CYCLES(16)) dut (
`else
   sci_acc_req_resp_gen dut (
`endif
      .clk(clk), .reset(reset), .req_vld(req_vld), .req_mode(req_mode), .req_res(req_res),
      .req_data(req_data), .intf_ready(intf_ready), .resp_gen_cmpltd(resp_gen_cmpltd),
      .core_start(core_start), .core_mode(core_mode), .core_res(core_res), .core_arg(core_arg),
      .core_done(core_done), .core_result(core_result), .res_fifo_push(res_fifo_push),
      .res_fifo_data_in(res_fifo_data_in), .res_fifo_full(res_fifo_full)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [3:0]  res;
      logic [31:0] data;
      int          done_at;
      int          early_done_at;
      logic [31:0] result;
      int          full_idx;
      int          full_cycles;
      logic [39:0] exp_resp;
      int          exp_start;
      int          exp_cmplt;
   } vec_t;

   vec_t vecs[8];
   int   n_vec;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] m, input logic [3:0] r, input logic [31:0] d,
                               input int dn, input int early, input logic [31:0] rs,
                               input int fi, input int fc, input logic [39:0] er,
                               input int es, input int ec);
      vec_t v;
      v.mode = m; v.res = r; v.data = d; v.done_at = dn; v.early_done_at = early;
      v.result = rs; v.full_idx = fi; v.full_cycles = fc; v.exp_resp = er;
      v.exp_start = es; v.exp_cmplt = ec;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int id);
      int         cyc, start_cyc, n_start, cmplt_cyc, nb, stall, first_push;
      logic [7:0] got[8];
      string      tag;
      tag        = $sformatf("v%0d", id);
      for (int i = 0; i < 8; i++) got[i] = 8'hxx;
      req_vld    = 1'b1; req_mode = v.mode; req_res = v.res; req_data = v.data;
      cyc        = 0; start_cyc = -1; n_start = 0; cmplt_cyc = -1; nb = 0;
      stall      = v.full_cycles;
      first_push = v.exp_cmplt - 5 - v.full_cycles;
      while (cmplt_cyc < 0 && cyc < 200) begin
         core_done     = (cyc == v.done_at) || (cyc == v.early_done_at);
         core_result   = (cyc == v.done_at) ? v.result : 32'hDEAD_BEEF;
         res_fifo_full = 1'b0;
         if (cyc >= first_push && nb == v.full_idx && stall > 0) begin
            res_fifo_full = 1'b1;
            stall--;
         end
         #1;
         if (core_start) begin
            n_start++;
            if (start_cyc < 0) start_cyc = cyc;
         end
         if (cyc == 1) begin
            check({tag, " busy_ready"}, 64'(intf_ready), 64'(0));
            check({tag, " latched"}, {26'd0, core_mode, core_res, core_arg}, {26'd0, v.mode, v.res, v.data});
         end
         if (res_fifo_push) begin
            if (nb < 8) got[nb] = res_fifo_data_in;
            nb++;
         end
         if (resp_gen_cmpltd) cmplt_cyc = cyc;
         @(negedge clk);
         cyc++;
      end
      if (cmplt_cyc < 0) $display("FAIL %s timeout: no completion within 200 cycles", tag);
      core_done = 1'b0; res_fifo_full = 1'b0; req_vld = 1'b0;
      #1;
      check({tag, " ready_after"}, {62'd0, intf_ready, res_fifo_push}, {62'd0, 1'b1, 1'b0});
      check({tag, " start_cycle"}, 64'(start_cyc), 64'(v.exp_start));
      check({tag, " start_count"}, 64'(n_start), 64'((v.exp_start < 0) ? 0 : 1));
      check({tag, " cmplt_cycle"}, 64'(cmplt_cyc), 64'(v.exp_cmplt));
      check({tag, " byte_count"}, 64'(nb), 64'(5));
      for (int b = 0; b < 5; b++)
         check($sformatf("%s byte%0d", tag, b), 64'(got[b]), 64'(v.exp_resp[39 - 8*b -: 8]));
      @(negedge clk);
   endtask

   initial begin
      int n_push, n_cmplt, n_st, n_notready;
      reset = 1'b1; req_vld = 1'b0; req_mode = '0; req_res = '0; req_data = '0;
      core_done = 1'b0; core_result = '0; res_fifo_full = 1'b0;

      n_vec = 0;
      vecs[n_vec++] = mk(2'd1, 4'h9, 32'h3F80_0000, 4, -1, 32'h3F57_0A3D, 0, 0, 40'h19_3F57_0A3D, 1, 10);
      vecs[n_vec++] = mk(2'd1, 4'h9, 32'h3F80_0000, 4, -1, 32'h3F57_0A3D, 2, 4, 40'h19_3F57_0A3D, 1, 14);
      vecs[n_vec++] = mk(2'd3, 4'h2, 32'h1234_5678, -1, -1, 32'h0, 0, 0, 40'hB2_0000_0000, -1, 6);
      vecs[n_vec++] = mk(2'd2, 4'h5, 32'hC000_0000, 3, 1, 32'h4000_0000, 0, 0, 40'h25_4000_0000, 1, 9);
      vecs[n_vec++] = mk(2'd0, 4'hF, 32'h3E80_0000, 2, -1, 32'h3F2D_F854, 0, 0, 40'h0F_3F2D_F854, 1, 8);
      vecs[n_vec++] = mk(2'd1, 4'h0, 32'h4049_0FDB, 5, -1, 32'h1234_5678, 0, 2, 40'h10_1234_5678, 1, 13);
`ifdef SCI_ACC_RESP_TIMEOUT_EN
      vecs[n_vec++] = mk(2'd0, 4'h1, 32'h3F00_0000, -1, -1, 32'h0, 0, 0, 40'h81_7FC0_0000, 1, 23);
`endif

      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs",
            {56'd0, intf_ready, resp_gen_cmpltd, core_start, res_fifo_push, 4'd0},
            {56'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
      check("reset_regs", {18'd0, core_mode, core_res, core_arg, res_fifo_data_in},
            {18'd0, 2'd0, 4'd0, 32'd0, 8'd0});
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < n_vec; i++) run_vec(vecs[i], i);

      // Reset while waiting on the core, then a stale core_done afterwards.
      req_vld = 1'b1; req_mode = 2'd1; req_res = 4'h3; req_data = 32'h3F80_0000;
      repeat (3) @(negedge clk);
      reset = 1'b1; req_vld = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      n_push = 0; n_cmplt = 0; n_st = 0; n_notready = 0;
      for (int c = 0; c < 12; c++) begin
         core_done   = (c == 2);
         core_result = 32'h4000_0000;
         #1;
         if (res_fifo_push)   n_push++;
         if (resp_gen_cmpltd) n_cmplt++;
         if (core_start)      n_st++;
         if (!intf_ready)     n_notready++;
         @(negedge clk);
      end
      core_done = 1'b0;
      check("rst_mid pushes", 64'(n_push), 64'(0));
      check("rst_mid cmplt", 64'(n_cmplt), 64'(0));
      check("rst_mid start", 64'(n_st), 64'(0));
      check("rst_mid not_ready", 64'(n_notready), 64'(0));
      check("rst_mid arg", 64'(core_arg), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sci_acc_req_resp_gen.md
Name: sci_acc_req_resp_gen

Overview:
- Engine-side responder for the accelerator request interface.
- Accepts one request (req_vld/req_mode/req_res/req_data) from the ROM-DMA requester and launches the compute core with it.
- Serializes the core result as a 5-byte response (header plus 4 data bytes) into the result FIFO, then pulses resp_gen_cmpltd so the requester can release and fetch the next instruction.

Parameters:
NUM_MODE_BITS, 2, width of req_mode (EXP=0, SIN=1, COS=2; 3 illegal)
NUM_RES_BITS, 4, width of req_res
IEEE_32BIT, 32, operand/result width
RES_FIFO_DATA_WIDTH, 8, result FIFO word width; 5 words per response
TIMEOUT_CYCLES, 1024, core watchdog limit (optional feature only)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high reset
req_vld  in  1  request valid; held high with stable payload until resp_gen_cmpltd
req_mode  in  NUM_MODE_BITS  function select
req_res  in  NUM_RES_BITS  resolution/iteration count
req_data  in  IEEE_32BIT  float operand
intf_ready  out  1  high only in IDLE
resp_gen_cmpltd  out  1  one-cycle completion pulse
core_start  out  1  one-cycle launch pulse
core_mode  out  NUM_MODE_BITS  latched mode
core_res  out  NUM_RES_BITS  latched res
core_arg  out  IEEE_32BIT  latched operand
core_done  in  1  core result valid pulse
core_result  in  IEEE_32BIT  core result, valid with core_done
res_fifo_push  out  1  push strobe
res_fifo_data_in  out  RES_FIFO_DATA_WIDTH  pushed byte
res_fifo_full  in  1  FIFO full

Behaviour:
- Reset values: state=IDLE; intf_ready=1; resp_gen_cmpltd=0; core_start=0; res_fifo_push=0; all latched registers and res_fifo_data_in=0.
- FSM states and transitions:
  - IDLE: when req_vld & intf_ready, latch mode/res/data. If mode is legal, go to START. If mode==3, set err=1 and result=0, then go to PUSH without starting the core.
  - START: core_start=1 for exactly one cycle, then go to WAIT_CORE.
  - WAIT_CORE: on core_done, capture core_result and go to PUSH. core_done is ignored in every other state, including the same cycle as core_start.
  - PUSH: 3-bit byte counter idx runs 0..4.
    - idx 0 sends the header: bit7=err, bits6:4=mode zero-extended, bits3:0=res.
    - idx 1..4 send result[31:24], [23:16], [15:8], [7:0].
    - res_fifo_push = !res_fifo_full. idx advances only on a push; data is held while full.
    - After the push at idx 4, go to CMPLT.
  - CMPLT: resp_gen_cmpltd=1 for one cycle; clear idx and err; go to IDLE.
- Requester handshake: req_vld is high during CMPLT and low on the following cycle. IDLE therefore never re-captures the same request.
- Latency with no backpressure and core_done k cycles after core_start: header push at cycle k+2 after acceptance, completion pulse at cycle k+7. Each cycle of FIFO-full stall adds one cycle.
- No second request is accepted before completion; intf_ready is low in all non-IDLE states.
- Reset asserted mid-operation: return to IDLE immediately with reset values, no partial completion pulse, and any later core_done is ignored.

Optional Feature:
- Macro SCI_ACC_RESP_TIMEOUT_EN.
- Defined: WAIT_CORE runs a cycle counter. If the counter reaches TIMEOUT_CYCLES without core_done, the block uses result=32'h7FC00000 (quiet NaN), sets err=1 and goes to PUSH. A core_done arriving in the same cycle as the timeout wins: normal result, err=0.
- Undefined: no counter; WAIT_CORE waits indefinitely.

Decomposition:
- sci_acc_pkg holds:
  - the mode enum (EXP, SIN, COS)
  - width constants NUM_MODE_BITS, NUM_RES_BITS, IEEE_32BIT, RES_FIFO_DATA_WIDTH
  - NUM_RESP_BYTES=5
  - header bit positions
  - the QNAN constant
- One sub-module, resp_byte_serializer: a 40-bit load register, the byte counter and the full-gated push logic, with a done output to the FSM.

Test Plan:
1. Req mode=SIN(1), res=4'h9, data=32'h3F800000; core_done with result 32'h3F570A3D 3 cycles after core_start -> FIFO receives 8'h19, 3F, 57, 0A, 3D; resp_gen_cmpltd pulses 10 cycles after acceptance; intf_ready high the next cycle.
2. Same request with res_fifo_full high for 4 cycles at idx 2 -> byte 8'h57 is held and pushed once after full drops; completion delayed by exactly 4 cycles; no duplicate or missing bytes.
3. Req mode=3, res=4'h2 -> no core_start; FIFO receives 8'hB2, 00, 00, 00, 00; completion pulse.
4. Reset asserted in WAIT_CORE; core_done asserted 2 cycles after reset is released -> no FIFO pushes, no completion pulse, intf_ready=1.
5. core_done asserted in the same cycle as core_start, then again 2 cycles later with result 32'h40000000 -> the first pulse is ignored; data bytes are 40, 00, 00, 00.
6. (SCI_ACC_RESP_TIMEOUT_EN defined, TIMEOUT_CYCLES=16) mode=EXP, res=1, no core_done -> after 16 cycles FIFO receives 8'h81, 7F, C0, 00, 00; completion pulse.
